// File: rtl/agc_pkg.sv
// Constants shared by the auto-gain stage and its downstream consumers.
// Includes the gain index encoding, the ADC overrange code, mV reciprocals and meter FSM states.
package agc_pkg;

    localparam logic [1:0] GAIN_3     = 2'd0;
    localparam logic [1:0] GAIN_6_5   = 2'd1;
    localparam logic [1:0] GAIN_13_5  = 2'd2;
    localparam logic [1:0] GAIN_29_25 = 2'd3;

    localparam logic [11:0] OVER_VOLTAGE_THRESHOLD = 12'd3941;

    // Q16 of 2000 mV / 4096 codes / gain, indexed by gain index.
    localparam logic [13:0] RECIP_Q16 [4] = '{14'd10667, 14'd4923, 14'd2370, 14'd1094};

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StEval,
        StMul,
        StDone
    } meter_state_e;

endpackage

// File: rtl/peak_hold.sv
// Running min/max tracker with an overrange flag for 12-bit ADC codes.
// Clear restores the empty-window state (max=0, min=all ones); clear wins over enable.
module peak_hold
    import agc_pkg::*;
#(
    parameter logic [11:0] THRESH = OVER_VOLTAGE_THRESHOLD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [11:0] data_i,
    output logic [11:0] max_o,
    output logic [11:0] min_o,
    output logic        ovr_o
);

    logic [11:0] max_q, max_d;
    logic [11:0] min_q, min_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        max_d = max_q;
        min_d = min_q;
        ovr_d = ovr_q;
        if (clear_i) begin
            max_d = '0;
            min_d = '1;
            ovr_d = 1'b0;
        end else if (en_i) begin
            if (data_i > max_q) max_d = data_i;
            if (data_i < min_q) min_d = data_i;
            if (data_i >= THRESH) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            min_q <= '1;
            ovr_q <= 1'b0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
            ovr_q <= ovr_d;
        end
    end

    assign max_o = max_q;
    assign min_o = min_q;
    assign ovr_o = ovr_q;

endmodule

// File: rtl/amplitude_meter.sv
// Windowed peak-to-peak meter: accumulates WINDOW samples while the gain loop is stable,
// then scales pkpk by the latched gain reciprocal into input-referred millivolts.
module amplitude_meter
    import agc_pkg::*;
#(
    parameter int unsigned WINDOW      = 512,
    parameter logic [11:0] OVER_THRESH = OVER_VOLTAGE_THRESHOLD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] adc_data_i,
    input  logic        adc_valid_i,
    input  logic [1:0]  gain_idx_i,
    input  logic        agc_stable_i,
    output logic [11:0] amp_mv_o,
    output logic        amp_valid_o,
    output logic        overrange_o,
    output logic        abort_o
);

    localparam int unsigned CntW = $clog2(WINDOW);
    localparam logic [CntW-1:0] CntLast = CntW'(WINDOW - 1);

    meter_state_e    state_q, state_d;
    logic [1:0]      g_lat_q, g_lat_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [11:0]     pkpk_q, pkpk_d;
    logic [12:0]     prod_q, prod_d;
    logic [11:0]     amp_mv_q, amp_mv_d;
    logic            ovr_out_q, ovr_out_d;
    logic            amp_valid_q, amp_valid_d;
    logic            abort_q, abort_d;

    logic        ph_clear, ph_en, ph_ovr, abort_cond;
    logic [11:0] ph_max, ph_min;
    logic [28:0] prod_full;

    peak_hold #(
        .THRESH(OVER_THRESH)
    ) u_peak_hold (
        .clk    (clk),
        .rst    (rst),
        .clear_i(ph_clear),
        .en_i   (ph_en),
        .data_i (adc_data_i),
        .max_o  (ph_max),
        .min_o  (ph_min),
        .ovr_o  (ph_ovr)
    );

    // +32768 rounds the Q16 product before keeping the integer part.
    assign prod_full  = 29'(pkpk_q) * 29'(RECIP_Q16[g_lat_q]) + 29'd32768;
    assign abort_cond = !agc_stable_i || (gain_idx_i != g_lat_q);

    always_comb begin
        state_d     = state_q;
        g_lat_d     = g_lat_q;
        cnt_d       = cnt_q;
        pkpk_d      = pkpk_q;
        prod_d      = prod_q;
        amp_mv_d    = amp_mv_q;
        ovr_out_d   = ovr_out_q;
        amp_valid_d = 1'b0;
        abort_d     = 1'b0;
        ph_clear    = 1'b0;
        ph_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (agc_stable_i) begin
                    state_d  = StAccum;
                    g_lat_d  = gain_idx_i;
                    cnt_d    = '0;
                    ph_clear = 1'b1;
                end
            end
            StAccum: begin
                // Abort beats a coincident sample; that sample is dropped.
                if (abort_cond) begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else if (adc_valid_i) begin
                    ph_en = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) state_d = StEval;
                end
            end
            StEval: begin
                pkpk_d  = ph_max - ph_min;
                state_d = StMul;
            end
            StMul: begin
                prod_d  = 13'(prod_full >> 16);
                state_d = StDone;
            end
            StDone: begin
                amp_mv_d    = prod_q[12] ? 12'hFFF : prod_q[11:0];
                ovr_out_d   = ph_ovr;
                amp_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            g_lat_q     <= '0;
            cnt_q       <= '0;
            pkpk_q      <= '0;
            prod_q      <= '0;
            amp_mv_q    <= '0;
            ovr_out_q   <= 1'b0;
            amp_valid_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_lat_q     <= g_lat_d;
            cnt_q       <= cnt_d;
            pkpk_q      <= pkpk_d;
            prod_q      <= prod_d;
            amp_mv_q    <= amp_mv_d;
            ovr_out_q   <= ovr_out_d;
            amp_valid_q <= amp_valid_d;
            abort_q     <= abort_d;
        end
    end

    assign amp_mv_o    = amp_mv_q;
    assign amp_valid_o = amp_valid_q;
    assign overrange_o = ovr_out_q;
    assign abort_o     = abort_q;

endmodule

// File: tb/tb_amplitude_meter.sv
// Scoreboard bench for amplitude_meter with an 8-sample window: expected results are queued
// when a window is driven and checked (value, overrange, latency) when amp_valid pulses.
module tb_amplitude_meter;

    localparam int unsigned WIN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [1:0]  gain_idx;
    logic        agc_stable;
    logic [11:0] amp_mv;
    logic        amp_valid;
    logic        overrange;
    logic        abort;

    amplitude_meter #(
        .WINDOW     (WIN),
        .OVER_THRESH(12'd3941)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc_data_i  (adc_data),
        .adc_valid_i (adc_valid),
        .gain_idx_i  (gain_idx),
        .agc_stable_i(agc_stable),
        .amp_mv_o    (amp_mv),
        .amp_valid_o (amp_valid),
        .overrange_o (overrange),
        .abort_o     (abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] amp;
        logic        ovr;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   n_abort = 0;
    logic abort_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each amp_valid and polices abort pulse width.
    always @(negedge clk) begin
        exp_t e;
        if (amp_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_amp_valid: cycle=%0d amp_mv=%0d, required no result",
                         cyc, amp_mv);
            end else begin
                e = sb.pop_front();
                if (amp_mv !== e.amp || overrange !== e.ovr || cyc != e.due) begin
                    errors++;
                    $display("FAIL result: amp_mv=%0d ovr=%b cycle=%0d, required amp_mv=%0d ovr=%b cycle=%0d",
                             amp_mv, overrange, cyc, e.amp, e.ovr, e.due);
                end
            end
        end
        if (abort === 1'b1) begin
            n_abort++;
            checks++;
            if (abort_prev === 1'b1) begin
                errors++;
                $display("FAIL abort_width: abort high two cycles at cycle=%0d, required one", cyc);
            end
        end
        abort_prev = abort;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_samples(input logic [11:0] s[WIN], input logic [11:0] ea,
                                 input logic eo);
        for (int i = 0; i < int'(WIN); i++) begin
            @(negedge clk);
            adc_data  = s[i];
            adc_valid = 1'b1;
        end
        @(negedge clk);
        adc_valid = 1'b0;
        sb.push_back('{amp: ea, ovr: eo, due: cyc + 3});
    endtask

    task automatic wait_result(input string name);
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_window(input logic [1:0] g, input logic [11:0] s[WIN],
                              input logic [11:0] ea, input logic eo, input string name);
        @(negedge clk);
        gain_idx   = g;
        agc_stable = 1'b1;
        drive_samples(s, ea, eo);
        agc_stable = 1'b0;
        wait_result(name);
    endtask

    task automatic fill_alt(output logic [11:0] s[WIN], input logic [11:0] a,
                            input logic [11:0] b);
        for (int i = 0; i < int'(WIN); i++) s[i] = (i % 2 == 0) ? a : b;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        adc_data   = '0;
        adc_valid  = 1'b0;
        gain_idx   = 2'd0;
        agc_stable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (amp_mv !== 12'd0 || amp_valid !== 1'b0 || overrange !== 1'b0 || abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: amp_mv=%0d valid=%b ovr=%b abort=%b, required all 0",
                     amp_mv, amp_valid, overrange, abort);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_gains;
        logic [11:0] s[WIN];
        fill_alt(s, 12'd500, 12'd3500);
        run_window(2'd0, s, 12'd488, 1'b0, "gain0_window");
        run_window(2'd3, s, 12'd50, 1'b0, "gain3_window");
        run_window(2'd1, s, 12'd225, 1'b0, "gain1_window");
        run_window(2'd2, s, 12'd108, 1'b0, "gain2_window");
    endtask

    task automatic test_overrange;
        logic [11:0] s[WIN];
        fill_alt(s, 12'd500, 12'd3500);
        s[3] = 12'd3941;
        run_window(2'd0, s, 12'd560, 1'b1, "ovr_at_thresh");
        s[3] = 12'd3940;
        run_window(2'd0, s, 12'd560, 1'b0, "ovr_below_thresh");
        fill_alt(s, 12'd500, 12'd3500);
        run_window(2'd0, s, 12'd488, 1'b0, "ovr_clean_after");
    endtask

    task automatic test_back_to_back;
        logic [11:0] s[WIN];
        fill_alt(s, 12'd500, 12'd3500);
        @(negedge clk);
        gain_idx   = 2'd0;
        agc_stable = 1'b1;
        drive_samples(s, 12'd488, 1'b0);
        // Junk samples in the inter-window gap must not leak into the next window.
        adc_data  = 12'd4095;
        adc_valid = 1'b1;
        repeat (3) @(negedge clk);
        fill_alt(s, 12'd1000, 12'd2000);
        drive_samples(s, 12'd163, 1'b0);
        agc_stable = 1'b0;
        wait_result("back_to_back");
    endtask

    task automatic test_abort_gain;
        logic [11:0] s[WIN];
        int v0, a0;
        v0 = n_valid;
        a0 = n_abort;
        @(negedge clk);
        gain_idx   = 2'd0;
        agc_stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            adc_data  = (i % 2 == 0) ? 12'd500 : 12'd3500;
            adc_valid = 1'b1;
        end
        @(negedge clk);
        adc_valid = 1'b0;
        gain_idx  = 2'd1;
        @(negedge clk);
        checks++;
        if (abort !== 1'b1) begin
            errors++;
            $display("FAIL abort_on_gain_change: abort=%b, required 1", abort);
        end
        fill_alt(s, 12'd500, 12'd3500);
        drive_samples(s, 12'd225, 1'b0);
        agc_stable = 1'b0;
        wait_result("window_after_gain_abort");
        checks++;
        if (n_valid - v0 != 1 || n_abort - a0 != 1) begin
            errors++;
            $display("FAIL gain_abort_counts: valids=%0d aborts=%0d, required 1 and 1",
                     n_valid - v0, n_abort - a0);
        end
    endtask

    task automatic test_abort_stable;
        logic [11:0] s[WIN];
        int v0, a0;
        v0 = n_valid;
        a0 = n_abort;
        @(negedge clk);
        gain_idx   = 2'd0;
        agc_stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            adc_data  = 12'd1500;
            adc_valid = 1'b1;
        end
        @(negedge clk);
        adc_data   = 12'd4000;
        agc_stable = 1'b0;
        @(negedge clk);
        adc_valid = 1'b0;
        checks++;
        if (abort !== 1'b1) begin
            errors++;
            $display("FAIL abort_on_stable_drop: abort=%b, required 1", abort);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (n_valid != v0 || n_abort - a0 != 1) begin
            errors++;
            $display("FAIL stable_abort_idle: valids=%0d aborts=%0d, required 0 and 1",
                     n_valid - v0, n_abort - a0);
        end
        fill_alt(s, 12'd500, 12'd3500);
        run_window(2'd0, s, 12'd488, 1'b0, "window_after_stable_abort");
    endtask

    task automatic test_reset_mid;
        logic [11:0] s[WIN];
        int v0, a0;
        v0 = n_valid;
        a0 = n_abort;
        @(negedge clk);
        gain_idx   = 2'd0;
        agc_stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            adc_data  = 12'd3990;
            adc_valid = 1'b1;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (amp_mv !== 12'd0 || amp_valid !== 1'b0 || overrange !== 1'b0 || abort !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: amp_mv=%0d valid=%b ovr=%b abort=%b, required all 0",
                     amp_mv, amp_valid, overrange, abort);
        end
        @(negedge clk);
        adc_valid  = 1'b0;
        agc_stable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (n_valid != v0 || n_abort != a0) begin
            errors++;
            $display("FAIL reset_no_events: valids=%0d aborts=%0d, required 0 and 0",
                     n_valid - v0, n_abort - a0);
        end
        fill_alt(s, 12'd2048, 12'd2048);
        run_window(2'd0, s, 12'd0, 1'b0, "const_after_reset");
    endtask

    initial begin
        test_reset();
        test_gains();
        test_overrange();
        test_back_to_back();
        test_abort_gain();
        test_abort_stable();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
